// File: rtl/sdram_stream_reader.sv
`timescale 1ns/1ps
// sdram_stream_reader: splits a linear read job into row-safe bursts and streams the words out of a local FIFO
module sdram_stream_reader #(
  parameter int XWIDTH  = 20,
  parameter int COLBITS = 8,
  parameter int DWIDTH  = 16,
  parameter int FIFO_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [XWIDTH-1:0] base_addr,
  input  logic [XWIDTH-1:0] word_count,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [XWIDTH-1:0] rd_addr,
  output logic [3:0]        rd_len,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [DWIDTH-1:0] rd_data,
  input  logic              rd_rdy,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int PW = FIFO_AW + 1;
  localparam int CW = COLBITS + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1 << FIFO_AW);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, ABORT} state_e;
  state_e state_q, state_d;
  logic [XWIDTH-1:0] cur_addr_q, cur_addr_d, remaining_q, remaining_d, rd_addr_q, rd_addr_d;
  logic [PW-1:0] inflight_q, inflight_d, wp_q, wp_d, rp_q, rp_d, avail;
  logic [3:0] rd_len_q, rd_len_d;
  logic rd_req_q, rd_req_d, busy_q, busy_d, done_q, done_d;
  logic [DWIDTH-1:0] mem_q [2**FIFO_AW];
  logic [CW-1:0] room;
  logic [4:0] len_cnt, len, ack_len;
  logic abort_now, acked, rdy_ok, push, pop;

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign rd_len    = rd_len_q;
  assign rd_req    = rd_req_q;
  assign out_valid = wp_q != rp_q;
  assign out_data  = out_valid ? mem_q[rp_q[FIFO_AW-1:0]] : '0;

  // next burst length clipped by 16, words left and distance to the end of the row; free space not yet promised
  always_comb begin
    room = {1'b1, {COLBITS{1'b0}}} - {1'b0, cur_addr_q[COLBITS-1:0]};
    len_cnt = (remaining_q < XWIDTH'(16)) ? remaining_q[4:0] : 5'd16;
    len = (room < CW'(len_cnt)) ? room[4:0] : len_cnt;
    avail = DEPTH - (wp_q - rp_q) - inflight_q;
  end

  // job FSM, burst bookkeeping and FIFO pointer updates
  always_comb begin
    state_d = state_q;
    cur_addr_d = cur_addr_q;
    remaining_d = remaining_q;
    rd_addr_d = rd_addr_q;
    rd_len_d = rd_len_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ack_len = {1'b0, rd_len_q} + 5'd1;
    acked = rd_req_q && rd_ack;
    rd_req_d = rd_req_q && !acked;
    abort_now = stop && busy_q && state_q != ABORT;
    rdy_ok = rd_rdy && inflight_q != '0;
    push = rdy_ok && state_q != ABORT && !abort_now;
    pop = out_valid && out_ready;
    inflight_d = inflight_q + (acked ? PW'(ack_len) : '0) - (rdy_ok ? PW'(1) : '0);
    wp_d = wp_q + (push ? PW'(1) : '0);
    rp_d = abort_now ? wp_q : rp_q + (pop ? PW'(1) : '0);
    case (state_q)
      IDLE: if (start) begin
        cur_addr_d = base_addr;
        remaining_d = word_count;
        busy_d = word_count != '0;
        done_d = word_count == '0;
        state_d = word_count != '0 ? ISSUE : IDLE;
      end
      ISSUE: if (remaining_q == '0) state_d = DRAIN;
        else if (avail >= PW'(len)) begin
          rd_addr_d = cur_addr_q;
          rd_len_d = 4'(len - 5'd1);
          rd_req_d = 1'b1;
          state_d = WAIT;
        end
      WAIT: if (acked) begin
        cur_addr_d = cur_addr_q + XWIDTH'(ack_len);
        remaining_d = remaining_q - XWIDTH'(ack_len);
        state_d = ISSUE;
      end
      DRAIN: if (inflight_q == '0 && !out_valid) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      ABORT: if (!rd_req_q && inflight_q == '0) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_now) begin
      state_d = ABORT;
      rd_req_d = rd_req_q && !acked;
      done_d = 1'b0;
      busy_d = busy_q;
    end
  end

  // state and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cur_addr_q <= '0;
      remaining_q <= '0;
      rd_addr_q <= '0;
      rd_len_q <= '0;
      rd_req_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      inflight_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      state_q <= state_d;
      cur_addr_q <= cur_addr_d;
      remaining_q <= remaining_d;
      rd_addr_q <= rd_addr_d;
      rd_len_q <= rd_len_d;
      rd_req_q <= rd_req_d;
      busy_q <= busy_d;
      done_q <= done_d;
      inflight_q <= inflight_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
    end

  // FIFO storage, written only with words that are still wanted
  always_ff @(posedge clk)
    if (push) mem_q[wp_q[FIFO_AW-1:0]] <= rd_data;

  // a returned word with nothing outstanding means the controller broke protocol
  assert property (@(posedge clk) disable iff (!rst_n) rd_rdy |-> inflight_q != '0);
endmodule
